xpm_memory_sdpram: RTL and testbench
====================================

XPM_MEMORY_SDPRAM -- requirements
Module: xpm_memory_sdpram

Interface
REQ-001 SHALL have parameter ADDR_WIDTH_A, default 6, meaning write address width.
REQ-002 SHALL have parameter ADDR_WIDTH_B, default 6, meaning read address width; must equal ADDR_WIDTH_A.
REQ-003 SHALL have parameter WRITE_DATA_WIDTH_A, default 32, meaning write word width.
REQ-004 SHALL have parameter READ_DATA_WIDTH_B, default 32, meaning read word width; must equal WRITE_DATA_WIDTH_A.
REQ-005 SHALL have parameter BYTE_WRITE_WIDTH_A, default 32, meaning write granularity; only the value WRITE_DATA_WIDTH_A (word-wide) is supported.
REQ-006 SHALL have parameter MEMORY_SIZE, default 2048, meaning total bits; DEPTH = MEMORY_SIZE / WRITE_DATA_WIDTH_A, with DEPTH <= 2^ADDR_WIDTH_A.
REQ-007 SHALL have parameter READ_LATENCY_B, default 1, meaning read latency in clk cycles; legal values are 0, 1 and 2.
REQ-008 SHALL have parameter READ_RESET_VALUE_B, default "0", meaning the doutb register value held in reset; it is a hex string converted to a READ_DATA_WIDTH_B-bit constant.
REQ-009 SHALL have parameter MEMORY_PRIMITIVE, default "auto", meaning an implementation hint with no functional effect.
REQ-010 SHALL have parameter WRITE_MODE_B, default "read_first", meaning collision policy; only "read_first" is supported.
REQ-011 SHALL have port clk  input  1  meaning single clock for both ports.
REQ-012 SHALL have port rst_n  input  1  meaning reset, asynchronous, active-low.
REQ-013 SHALL have port ena  input  1  meaning write port enable.
REQ-014 SHALL have port wea  input  1  meaning write enable.
REQ-015 SHALL have port addra  input  ADDR_WIDTH_A  meaning write address.
REQ-016 SHALL have port dina  input  WRITE_DATA_WIDTH_A  meaning write data.
REQ-017 SHALL have port enb  input  1  meaning read enable.
REQ-018 SHALL have port regceb  input  1  meaning final output register clock enable.
REQ-019 SHALL have port addrb  input  ADDR_WIDTH_B  meaning read address.
REQ-020 SHALL have port doutb  output  READ_DATA_WIDTH_B  meaning read data.
REQ-021 SHALL have port sleep  input  1  meaning power-save request; ignored.
REQ-022 SHALL have ports injectsbiterra and injectdbiterra  input  1 each  meaning ECC error injection; ignored.
REQ-023 SHALL have ports sbiterrb and dbiterrb  output  1 each  meaning ECC status; both tied to 0 (no ECC).

Function
REQ-024 SHALL store DEPTH words; on a clk rising edge with ena && wea && addra < DEPTH, mem[addra] <= dina; out-of-range writes SHALL be dropped.
REQ-025 SHALL initialise all memory words to 0 at time zero; memory contents SHALL NOT be affected by rst_n.
REQ-026 With READ_LATENCY_B=0, doutb SHALL equal mem[addrb] combinationally, independent of enb, regceb and rst_n; a write becomes visible after the writing edge.
REQ-027 With READ_LATENCY_B=1, on a clk edge with enb=1, doutb <= mem[addrb], sampled before the same-edge write (read_first: a simultaneous write to the same address returns the old data); with enb=0, doutb SHALL hold.
REQ-028 With READ_LATENCY_B=2, stage1 <= mem[addrb] when enb=1, and doutb <= stage1 when regceb=1; each stage otherwise holds.
REQ-029 A read with addrb >= DEPTH SHALL return 0.
REQ-030 Write and read ports SHALL operate independently; simultaneous accesses to different addresses SHALL both complete in the same cycle.

Reset
REQ-031 While rst_n=0, all read pipeline registers (stage1 and doutb) SHALL immediately take the value READ_RESET_VALUE_B, asynchronously.
REQ-032 During reset, writes SHALL still update memory; reads SHALL resume on the first clk edge after rst_n rises.
REQ-033 Reset asserted mid-read SHALL discard the in-flight read data.

Verification
REQ-034 Latency 1, DEPTH 32, width 8: write 0xA5 to address 3, then drive addrb=3 with enb=1 -> doutb=0xA5 one edge later.
REQ-035 Latency 1: same edge writes 0x11 to address 5 (which held 0x22) while reading address 5 -> doutb=0x22; the next read returns 0x11.
REQ-036 Latency 0: write 0x7E to address 0, then set addrb=0 -> doutb=0x7E immediately after the writing edge, with enb=0.
REQ-037 Latency 1: doutb=0x5A, then rst_n pulled low between edges -> doutb=0x00 at once; memory still returns 0x5A after reset.
REQ-038 Latency 2: read address 4 (0x33) with regceb=0 then regceb=1 -> doutb changes to 0x33 only on the regceb=1 edge.
REQ-039 Walk all 32 addresses with data = address XOR 0xFF, then read them back -> every word matches; sbiterrb and dbiterrb stay 0.

Source files
------------

// File: rtl/xpm_memory_sdpram.sv
// -----------------------------------------------------------------------------
// xpm_memory_sdpram
// Simple dual-port RAM with one clock: port A writes, port B reads.
// The read path can be combinational or pipelined through one or two
// registers. Collisions are read-first: a read on the same edge as a write
// to the same address returns the old word.
//
// Ports
//   clk            single clock for both ports
//   rst_n          async active-low reset for the read pipeline registers only
//   ena, wea       write port enable / write enable
//   addra, dina    write address / write data
//   enb            read enable (loads the first read register)
//   regceb         clock enable of the final output register (latency 2)
//   addrb          read address
//   doutb          read data
//   sleep          power-save request, ignored
//   injectsbiterra, injectdbiterra  ECC error injection, ignored
//   sbiterrb, dbiterrb              ECC status, tied low (no ECC)
// -----------------------------------------------------------------------------
module xpm_memory_sdpram #(
  parameter int    ADDR_WIDTH_A       = 6,
  parameter int    ADDR_WIDTH_B       = 6,
  parameter int    WRITE_DATA_WIDTH_A = 32,
  parameter int    READ_DATA_WIDTH_B  = 32,
  parameter int    BYTE_WRITE_WIDTH_A = 32,
  parameter int    MEMORY_SIZE        = 2048,
  parameter int    READ_LATENCY_B     = 1,
  parameter        READ_RESET_VALUE_B = "0",
  parameter string MEMORY_PRIMITIVE   = "auto",
  parameter string WRITE_MODE_B       = "read_first"
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic                          wea,
  input  logic [ADDR_WIDTH_A-1:0]       addra,
  input  logic [WRITE_DATA_WIDTH_A-1:0] dina,
  input  logic                          enb,
  input  logic                          regceb,
  input  logic [ADDR_WIDTH_B-1:0]       addrb,
  output logic [READ_DATA_WIDTH_B-1:0]  doutb,
  input  logic                          sleep,
  input  logic                          injectsbiterra,
  input  logic                          injectdbiterra,
  output logic                          sbiterrb,
  output logic                          dbiterrb
);

  localparam int DEPTH = MEMORY_SIZE / WRITE_DATA_WIDTH_A;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // One extra bit so DEPTH == 2**ADDR_WIDTH is still representable.
  localparam logic [ADDR_WIDTH_A:0] DEPTH_A = (ADDR_WIDTH_A + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH_B:0] DEPTH_B = (ADDR_WIDTH_B + 1)'(DEPTH);

  // Hex string (up to 16 characters) to a read-width constant.
  // NUL padding bytes from the zero-extension are skipped.
  function automatic logic [READ_DATA_WIDTH_B-1:0] hex_to_val(input logic [127:0] s);
    logic [READ_DATA_WIDTH_B-1:0] v;
    logic [7:0]                   c;
    logic [3:0]                   d;
    v = '0;
    for (int i = 15; i >= 0; i--) begin
      c = s[8*i +: 8];
      if (c != 8'h00) begin
        if (c >= 8'h30 && c <= 8'h39)      d = 4'(c - 8'h30);
        else if (c >= 8'h61 && c <= 8'h66) d = 4'(c - 8'h57);
        else if (c >= 8'h41 && c <= 8'h46) d = 4'(c - 8'h37);
        else                               d = 4'h0;
        v = (v << 4) | READ_DATA_WIDTH_B'(d);
      end
    end
    return v;
  endfunction

  localparam logic [READ_DATA_WIDTH_B-1:0] RST_VAL = hex_to_val(128'(READ_RESET_VALUE_B));

  // Implementation hint only; carries no behaviour.
  localparam bit unused_prim_hint = (MEMORY_PRIMITIVE == "");

  if (ADDR_WIDTH_B != ADDR_WIDTH_A)             begin : g_chk_aw  $error("ADDR_WIDTH_B must equal ADDR_WIDTH_A"); end
  if (READ_DATA_WIDTH_B != WRITE_DATA_WIDTH_A)  begin : g_chk_dw  $error("READ_DATA_WIDTH_B must equal WRITE_DATA_WIDTH_A"); end
  if (BYTE_WRITE_WIDTH_A != WRITE_DATA_WIDTH_A) begin : g_chk_bw  $error("only word-wide writes are supported"); end
  if (WRITE_MODE_B != "read_first")             begin : g_chk_wm  $error("only read_first collision mode is supported"); end
  if (READ_LATENCY_B < 0 || READ_LATENCY_B > 2) begin : g_chk_lat $error("READ_LATENCY_B must be 0, 1 or 2"); end

  // Storage is never reset; it starts cleared.
  logic [WRITE_DATA_WIDTH_A-1:0] mem [DEPTH] = '{default: '0};

  logic                         wr_in_range;
  logic                         rd_in_range;
  logic [IDX_W-1:0]             wr_idx;
  logic [IDX_W-1:0]             rd_idx;
  logic [READ_DATA_WIDTH_B-1:0] rd_word;
  logic                         unused_ok;

  assign wr_in_range = ({1'b0, addra} < DEPTH_A);
  assign rd_in_range = ({1'b0, addrb} < DEPTH_B);
  assign wr_idx      = addra[IDX_W-1:0];
  assign rd_idx      = addrb[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (ena && wea && wr_in_range)
      mem[wr_idx] <= dina;
  end

  always_comb begin
    rd_word = '0;
    if (rd_in_range)
      rd_word = mem[rd_idx];
  end

  if (READ_LATENCY_B == 0) begin : g_lat0
    assign doutb = rd_word;
  end else if (READ_LATENCY_B == 1) begin : g_lat1
    logic [READ_DATA_WIDTH_B-1:0] dout_p1;
    // Stage 1: array read; the same-edge write is not yet visible (read-first).
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   dout_p1 <= RST_VAL;
      else if (enb) dout_p1 <= rd_word;
    end
    assign doutb = dout_p1;
  end else begin : g_lat2
    logic [READ_DATA_WIDTH_B-1:0] rd_p1;
    logic [READ_DATA_WIDTH_B-1:0] dout_p2;
    // Stage 1: array read under enb. Stage 2: output register under regceb.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_p1   <= RST_VAL;
        dout_p2 <= RST_VAL;
      end else begin
        if (enb)    rd_p1   <= rd_word;
        if (regceb) dout_p2 <= rd_p1;
      end
    end
    assign doutb = dout_p2;
  end

  assign sbiterrb = 1'b0;
  assign dbiterrb = 1'b0;

  // Inputs that only some latency configurations consume, plus ignored pins.
  assign unused_ok = ^{sleep, injectsbiterra, injectdbiterra, enb, regceb, rst_n, unused_prim_hint};

endmodule

// File: tb/tb_xpm_memory_sdpram.sv
// -----------------------------------------------------------------------------
// tb_xpm_memory_sdpram
// Three instances (read latency 0, 1, 2) share one set of inputs. A reference
// model at each clock edge computes what every doutb must show after that
// edge and queues it; a monitor pops and compares shortly after the edge.
// A few spec scenarios additionally carry literal expected values.
// -----------------------------------------------------------------------------
module tb_xpm_memory_sdpram;

  localparam logic [7:0] R1 = 8'h00;  // reset value of latency-1 instance
  localparam logic [7:0] R2 = 8'h3C;  // reset value of latency-2 instance

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena, wea, enb, regceb;
  logic [5:0] addra, addrb;
  logic [7:0] dina;
  logic       sleep = 1'b0, inj_s = 1'b0, inj_d = 1'b0;

  logic [7:0] dout0, dout1, dout2;
  logic       sbe0, dbe0, sbe1, dbe1, sbe2, dbe2;

  int vectors     = 0;
  int miscompares = 0;

  xpm_memory_sdpram #(
    .ADDR_WIDTH_A(6), .ADDR_WIDTH_B(6), .WRITE_DATA_WIDTH_A(8), .READ_DATA_WIDTH_B(8),
    .BYTE_WRITE_WIDTH_A(8), .MEMORY_SIZE(256), .READ_LATENCY_B(0)
  ) u_l0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .enb(enb), .regceb(regceb), .addrb(addrb), .doutb(dout0), .sleep(sleep),
    .injectsbiterra(inj_s), .injectdbiterra(inj_d), .sbiterrb(sbe0), .dbiterrb(dbe0)
  );

  xpm_memory_sdpram #(
    .ADDR_WIDTH_A(6), .ADDR_WIDTH_B(6), .WRITE_DATA_WIDTH_A(8), .READ_DATA_WIDTH_B(8),
    .BYTE_WRITE_WIDTH_A(8), .MEMORY_SIZE(256), .READ_LATENCY_B(1)
  ) u_l1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .enb(enb), .regceb(regceb), .addrb(addrb), .doutb(dout1), .sleep(sleep),
    .injectsbiterra(inj_s), .injectdbiterra(inj_d), .sbiterrb(sbe1), .dbiterrb(dbe1)
  );

  xpm_memory_sdpram #(
    .ADDR_WIDTH_A(6), .ADDR_WIDTH_B(6), .WRITE_DATA_WIDTH_A(8), .READ_DATA_WIDTH_B(8),
    .BYTE_WRITE_WIDTH_A(8), .MEMORY_SIZE(256), .READ_LATENCY_B(2),
    .READ_RESET_VALUE_B("3C")
  ) u_l2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .enb(enb), .regceb(regceb), .addrb(addrb), .doutb(dout2), .sleep(sleep),
    .injectsbiterra(inj_s), .injectdbiterra(inj_d), .sbiterrb(sbe2), .dbiterrb(dbe2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [32];
  logic [7:0] m1, s2, m2;
  logic [7:0] q0[$], q1[$], q2[$];

  function automatic logic [7:0] mrd(input logic [5:0] a);
    return (a < 6'd32) ? ref_mem[a[4:0]] : 8'h00;
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
  end

  always @(posedge clk) begin : model
    logic [7:0] rv;
    rv = mrd(addrb);                 // old contents: read-first
    if (!rst_n) begin
      m1 = R1; s2 = R2; m2 = R2;
    end else begin
      if (enb)    m1 = rv;
      if (regceb) m2 = s2;
      if (enb)    s2 = rv;
    end
    if (ena && wea && addra < 6'd32) ref_mem[addra[4:0]] = dina;
    q0.push_back(mrd(addrb));        // combinational port sees the new write
    q1.push_back(m1);
    q2.push_back(m2);
  end

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    #1;
    if (q0.size() > 0) chk("lat0_doutb", dout0, q0.pop_front());
    if (q1.size() > 0) chk("lat1_doutb", dout1, q1.pop_front());
    if (q2.size() > 0) chk("lat2_doutb", dout2, q2.pop_front());
    chk("ecc_flags", {2'b00, sbe0, dbe0, sbe1, dbe1, sbe2, dbe2}, 8'h00);
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic ea, input logic we, input logic [5:0] aa, input logic [7:0] da,
                      input logic eb, input logic rc, input logic [5:0] ab);
    @(negedge clk);
    ena = ea; wea = we; addra = aa; dina = da;
    enb = eb; regceb = rc; addrb = ab;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    ena = 0; wea = 0; addra = '0; dina = '0; enb = 0; regceb = 0; addrb = '0;
    repeat (2) step(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;

    // Write 0xA5 to 3, read it back one edge later.
    step(1, 1, 6'd3, 8'hA5, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 6'd3);
    after_edge(); chk("wr_then_rd_a5", dout1, 8'hA5);
    step(0, 0, 0, 0, 0, 1, 6'd3);

    // Read-first collision on address 5.
    step(1, 1, 6'd5, 8'h22, 0, 0, 0);
    step(1, 1, 6'd5, 8'h11, 1, 0, 6'd5);
    after_edge(); chk("collision_old", dout1, 8'h22);
    step(0, 0, 0, 0, 1, 0, 6'd5);
    after_edge(); chk("collision_new", dout1, 8'h11);

    // Combinational port: new data visible right after the writing edge.
    step(1, 1, 6'd0, 8'h7E, 0, 0, 6'd0);
    after_edge(); chk("lat0_after_write", dout0, 8'h7E);

    // Output register clock enable on the two-stage path.
    step(1, 1, 6'd4, 8'h33, 0, 1, 6'd0);
    step(0, 0, 0, 0, 1, 0, 6'd4);
    step(0, 0, 0, 0, 0, 1, 6'd4);
    after_edge(); chk("lat2_regceb", dout2, 8'h33);

    // Reset between edges clears the read registers at once; memory survives,
    // and a write issued during reset still lands.
    step(1, 1, 6'd9, 8'h5A, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 6'd9);
    after_edge(); chk("pre_reset_5a", dout1, 8'h5A);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("async_reset_lat1", dout1, R1);
    chk("async_reset_lat2", dout2, R2);
    step(1, 1, 6'd10, 8'hC3, 1, 1, 6'd9);
    @(negedge clk) rst_n = 1'b1;
    step(0, 0, 0, 0, 1, 1, 6'd9);
    after_edge(); chk("post_reset_5a", dout1, 8'h5A);
    step(0, 0, 0, 0, 1, 1, 6'd10);
    after_edge(); chk("write_in_reset", dout1, 8'hC3);

    // Out-of-range write is dropped, out-of-range read returns 0.
    step(1, 1, 6'd40, 8'hEE, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 6'd40);
    after_edge(); chk("oor_read", dout1, 8'h00);
    step(0, 0, 0, 0, 1, 1, 6'd8);
    after_edge(); chk("oor_no_alias", dout1, 8'h00);

    // Address walk.
    for (int i = 0; i < 32; i++) step(1, 1, 6'(i), 8'(i) ^ 8'hFF, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      step(0, 0, 0, 0, 1, 1, 6'(i));
      after_edge(); chk("walk", dout1, 8'(i) ^ 8'hFF);
    end

    // Randomized traffic, including occasional reset cycles.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rst_n  = ($urandom_range(0, 39) != 0);
      ena    = 1'($urandom);
      wea    = 1'($urandom);
      addra  = 6'($urandom_range(0, 63));
      dina   = 8'($urandom);
      enb    = 1'($urandom);
      regceb = 1'($urandom);
      addrb  = ($urandom_range(0, 3) == 0) ? addra : 6'($urandom_range(0, 63));
    end

    @(negedge clk) rst_n = 1'b1;
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);
    after_edge();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
